id_scoreboard: RTL and testbench

ID_SCOREBOARD -- requirements
Module: id_scoreboard

---
 rtl/id_scoreboard.sv | 118 +++++++++++
 tb/tb_id_scoreboard.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// Register-dependency scoreboard for the decode stage.
// Tracks how many uncommitted writers target each architectural register
// and stalls decode on RAW hazards or when the writer window is full.
module id_scoreboard #(
  parameter int NREG         = 32,
  parameter int IDXW         = 5,
  parameter int MAX_INFLIGHT = 4,
  parameter int WB_BYPASS    = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              id_valid_i,
  input  logic [IDXW-1:0]                   id_rs1_idx_i,
  input  logic [IDXW-1:0]                   id_rs2_idx_i,
  input  logic                              id_rs1_used_i,
  input  logic                              id_rs2_used_i,
  input  logic                              id_wben_i,
  input  logic [IDXW-1:0]                   id_rd_idx_i,
  input  logic                              wb_valid_i,
  input  logic                              wb_wren_i,
  input  logic [IDXW-1:0]                   wb_rdid_i,
  input  logic                              flush_i,
  output logic                              stalln_pc,
  output logic                              stalln_id,
  output logic                              stalln_ex,
  output logic                              issue_o,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_o,
  output logic                              err_o
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  logic [CW-1:0] cnt [NREG];
  logic [CW-1:0] total;
  logic          err_q;

  logic wb_hit;
  logic rs1_bypass;
  logic rs2_bypass;
  logic rs1_haz;
  logic rs2_haz;
  logic full_haz;
  logic hazard;
  logic inc;
  logic dec;
  logic dec_ok;
  logic same_reg;
  logic inc_eff;
  logic dec_eff;
  logic underflow;

  // Hazard detection, issue decision and counter update qualifiers
  always_comb begin
    wb_hit     = wb_valid_i & wb_wren_i;
    rs1_bypass = (WB_BYPASS != 0) && wb_hit && (wb_rdid_i == id_rs1_idx_i)
                 && (cnt[id_rs1_idx_i] == CW'(1));
    rs2_bypass = (WB_BYPASS != 0) && wb_hit && (wb_rdid_i == id_rs2_idx_i)
                 && (cnt[id_rs2_idx_i] == CW'(1));
    rs1_haz    = id_rs1_used_i && (cnt[id_rs1_idx_i] != '0) && !rs1_bypass;
    rs2_haz    = id_rs2_used_i && (cnt[id_rs2_idx_i] != '0) && !rs2_bypass;
    // A full window only blocks instructions that would actually take a slot
    full_haz   = id_wben_i && (id_rd_idx_i != '0) && (total == CW'(MAX_INFLIGHT));
    hazard     = id_valid_i && (rs1_haz || rs2_haz || full_haz);
    issue_o    = id_valid_i && !hazard && !flush_i;
    inc        = issue_o && id_wben_i && (id_rd_idx_i != '0);
    dec        = wb_hit && (wb_rdid_i != '0);
    underflow  = dec && (cnt[wb_rdid_i] == '0);
    dec_ok     = dec && !underflow;
    // Issue and retire on the same register cancel out entirely
    same_reg   = inc && dec && (id_rd_idx_i == wb_rdid_i);
    inc_eff    = inc && !same_reg;
    dec_eff    = dec_ok && !same_reg;
  end

  assign stalln_pc  = ~hazard;
  assign stalln_id  = ~hazard;
  assign stalln_ex  = ~hazard;
  assign inflight_o = total;
  assign err_o      = err_q;

  // Per-register pending-writer counters; x0 never tracks anything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int i = 1; i < NREG; i++) begin
        if (inc_eff && (id_rd_idx_i == IDXW'(i)))
          cnt[i] <= cnt[i] + CW'(1);
        else if (dec_eff && (wb_rdid_i == IDXW'(i)))
          cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  // Total in-flight writer count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      total <= '0;
    else if (flush_i)
      total <= '0;
    else if (inc_eff && !dec_eff)
      total <= total + CW'(1);
    else if (dec_eff && !inc_eff)
      total <= total - CW'(1);
  end

  // Sticky underflow flag, only cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (!flush_i && underflow)
      err_q <= 1'b1;
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed self-checking testbench for id_scoreboard.
module tb_id_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid_i;
  logic [4:0] id_rs1_idx_i;
  logic [4:0] id_rs2_idx_i;
  logic       id_rs1_used_i;
  logic       id_rs2_used_i;
  logic       id_wben_i;
  logic [4:0] id_rd_idx_i;
  logic       wb_valid_i;
  logic       wb_wren_i;
  logic [4:0] wb_rdid_i;
  logic       flush_i;
  logic       stalln_pc;
  logic       stalln_id;
  logic       stalln_ex;
  logic       issue_o;
  logic [2:0] inflight_o;
  logic       err_o;

  int tests_run = 0;
  int tests_failed = 0;

  id_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_rs1_idx_i(id_rs1_idx_i), .id_rs2_idx_i(id_rs2_idx_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .id_wben_i(id_wben_i), .id_rd_idx_i(id_rd_idx_i),
    .wb_valid_i(wb_valid_i), .wb_wren_i(wb_wren_i), .wb_rdid_i(wb_rdid_i),
    .flush_i(flush_i),
    .stalln_pc(stalln_pc), .stalln_id(stalln_id), .stalln_ex(stalln_ex),
    .issue_o(issue_o), .inflight_o(inflight_o), .err_o(err_o)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle's worth of inputs, then let combinational outputs settle
  task automatic applyStimulus(input int valid, input int rs1, input int u1,
                               input int rs2, input int u2, input int wben, input int rd,
                               input int wbv, input int wbrd, input int flush);
    id_valid_i    = valid[0];
    id_rs1_idx_i  = 5'(rs1);
    id_rs1_used_i = u1[0];
    id_rs2_idx_i  = 5'(rs2);
    id_rs2_used_i = u2[0];
    id_wben_i     = wben[0];
    id_rd_idx_i   = 5'(rd);
    wb_valid_i    = wbv[0];
    wb_wren_i     = wbv[0];
    wb_rdid_i     = 5'(wbrd);
    flush_i       = flush[0];
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Writer to rd with no sources
  task automatic writer(input int rd);
    applyStimulus(1, 0, 0, 0, 0, 1, rd, 0, 0, 0);
  endtask

  // Retire rd with an empty decode slot
  task automatic retire(input int rd);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, rd, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] stalls();
    return 32'({stalln_pc, stalln_id, stalln_ex});
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();
    #12;
    checkOutput("reset_inflight", 32'(inflight_o), 0);
    checkOutput("reset_err", 32'(err_o), 0);
    checkOutput("reset_stalln", stalls(), 7);
    checkOutput("reset_issue", 32'(issue_o), 0);
    rst_n = 1'b1;
    tick();

    // RAW on x5 and writeback bypass
    writer(5);
    checkOutput("x5_issue", 32'(issue_o), 1);
    tick();
    checkOutput("x5_inflight", 32'(inflight_o), 1);
    applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("raw_x5_stalln_id", 32'(stalln_id), 0);
    checkOutput("raw_x5_issue", 32'(issue_o), 0);
    applyStimulus(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
    checkOutput("bypass_x5_stalln_id", 32'(stalln_id), 1);
    checkOutput("bypass_x5_issue", 32'(issue_o), 1);
    tick();
    checkOutput("x5_retired", 32'(inflight_o), 0);

    // Window full at four writers
    for (int r = 1; r <= 4; r++) begin
      writer(r);
      tick();
    end
    checkOutput("full_inflight", 32'(inflight_o), 4);
    writer(6);
    checkOutput("full_stalln_pc", 32'(stalln_pc), 0);
    checkOutput("full_issue", 32'(issue_o), 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 6, 1, 1, 0);
    checkOutput("full_retire_still_stalled", stalls(), 0);
    tick();
    checkOutput("full_after_retire", 32'(inflight_o), 3);
    writer(6);
    checkOutput("full_x6_issue", 32'(issue_o), 1);
    tick();
    checkOutput("full_refilled", 32'(inflight_o), 4);
    retire(2); tick();
    retire(3); tick();
    retire(4); tick();
    retire(6); tick();
    checkOutput("full_drained", 32'(inflight_o), 0);

    // Two writers to x7
    writer(7); tick();
    writer(7); tick();
    checkOutput("x7_two_inflight", 32'(inflight_o), 2);
    applyStimulus(1, 0, 0, 7, 1, 0, 0, 1, 7, 0);
    checkOutput("x7_cnt2_no_bypass", 32'(stalln_ex), 0);
    tick();
    checkOutput("x7_one_left", 32'(inflight_o), 1);
    applyStimulus(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
    checkOutput("x7_reader_stalled", 32'(issue_o), 0);
    applyStimulus(1, 0, 0, 7, 1, 0, 0, 1, 7, 0);
    checkOutput("x7_released", stalls(), 7);
    checkOutput("x7_reader_issue", 32'(issue_o), 1);
    tick();
    checkOutput("x7_drained", 32'(inflight_o), 0);

    // Same-cycle issue and retire on x9
    writer(9); tick();
    applyStimulus(1, 0, 0, 0, 0, 1, 9, 1, 9, 0);
    checkOutput("x9_same_issue", 32'(issue_o), 1);
    tick();
    checkOutput("x9_same_inflight", 32'(inflight_o), 1);
    applyStimulus(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("x9_cnt_still_1", 32'(stalln_id), 0);
    retire(9); tick();
    applyStimulus(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("x9_cleared", 32'(stalln_id), 1);

    // Underflow on x3, then flush with three writers in flight
    retire(3); tick();
    checkOutput("underflow_err", 32'(err_o), 1);
    checkOutput("underflow_total_held", 32'(inflight_o), 0);
    writer(10); tick();
    writer(11); tick();
    writer(12); tick();
    checkOutput("pre_flush_inflight", 32'(inflight_o), 3);
    applyStimulus(1, 0, 0, 0, 0, 1, 13, 1, 10, 1);
    checkOutput("flush_issue", 32'(issue_o), 0);
    tick();
    checkOutput("flush_inflight", 32'(inflight_o), 0);
    applyStimulus(1, 10, 1, 11, 1, 0, 0, 0, 0, 0);
    checkOutput("flush_stalln", stalls(), 7);
    checkOutput("flush_err_kept", 32'(err_o), 1);

    // Asynchronous reset mid-stream
    writer(1); tick();
    writer(2); tick();
    checkOutput("pre_reset_inflight", 32'(inflight_o), 2);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_inflight", 32'(inflight_o), 0);
    checkOutput("async_reset_err", 32'(err_o), 0);
    #1;
    rst_n = 1'b1;
    applyStimulus(1, 1, 1, 2, 1, 1, 1, 0, 0, 0);
    checkOutput("post_reset_stalln", stalls(), 7);
    tick();
    checkOutput("post_reset_inflight", 32'(inflight_o), 1);

    // Writes and retires of x0 are invisible to the scoreboard
    applyStimulus(1, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    checkOutput("x0_issue", 32'(issue_o), 1);
    tick();
    checkOutput("x0_no_count", 32'(inflight_o), 1);
    retire(0); tick();
    checkOutput("x0_retire_no_err", 32'(err_o), 0);
    checkOutput("x0_retire_total", 32'(inflight_o), 1);

    idle();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
